// File: rtl/maze_controller.sv
// maze_controller: game FSM owning player/exit positions, move validation via maze ROM and the interval timer.
module maze_controller #(
   parameter int START_BCOL         = 1,
   parameter int START_BROW         = 1,
   parameter int EXIT_BCOL          = 38,
   parameter int EXIT_BROW          = 27,
   parameter int TICKS_PER_INTERVAL = 50_000_000,
   parameter int MAX_INTERVALS      = 40,
   parameter int MAX_BCOL           = 39,
   parameter int MAX_BROW           = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_control,
   input  logic        i_up,
   input  logic        i_down,
   input  logic        i_left,
   input  logic        i_right,
   output logic        o_rom_en,
   output logic [10:0] o_rom_addr,
   input  logic [15:0] i_rom_data,
   output logic [5:0]  o_player_bcol,
   output logic [5:0]  o_player_brow,
   output logic [5:0]  o_exit_bcol,
   output logic [5:0]  o_exit_brow,
   output logic [5:0]  o_two_seconds_intervals,
   output logic        o_win,
   output logic        o_lose
);
   typedef enum logic [2:0] {IDLE, PLAY, REQ, CHECK, WIN, LOSE} state_t;
   localparam int TW = $clog2(TICKS_PER_INTERVAL + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_INTERVAL - 1);
   localparam logic [5:0] S_COL = 6'(START_BCOL), S_ROW = 6'(START_BROW);
   localparam logic [5:0] E_COL = 6'(EXIT_BCOL), E_ROW = 6'(EXIT_BROW);

   state_t         state_q, state_d;
   logic [5:0]     pcol_q, pcol_d, prow_q, prow_d, tcol_q, tcol_d, trow_q, trow_d;
   logic [5:0]     ivl_q, ivl_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic           rom_en_q, rom_en_d, win_q, lose_q, active;
   logic [10:0]    rom_addr_q, rom_addr_d;

   always_comb begin
      state_d = state_q;
      pcol_d  = pcol_q;
      prow_d  = prow_q;
      tcol_d  = tcol_q;
      trow_d  = trow_q;
      tick_d  = tick_q;
      ivl_d   = ivl_q;
      active  = state_q inside {PLAY, REQ, CHECK};
      if (active) begin
         tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
         ivl_d  = (tick_q == TICK_LAST) ? ivl_q + 6'd1 : ivl_q;
      end
      case (state_q)
         IDLE: state_d = i_control ? PLAY : IDLE;
         PLAY: begin
            // Target is latched even for rejected moves; it is only used after REQ.
            if (i_up) begin
               tcol_d  = pcol_q;
               trow_d  = prow_q - 6'd1;
               state_d = (prow_q != 6'd0) ? REQ : PLAY;
            end else if (i_down) begin
               tcol_d  = pcol_q;
               trow_d  = prow_q + 6'd1;
               state_d = (prow_q < 6'(MAX_BROW)) ? REQ : PLAY;
            end else if (i_left) begin
               tcol_d  = pcol_q - 6'd1;
               trow_d  = prow_q;
               state_d = (pcol_q != 6'd0) ? REQ : PLAY;
            end else if (i_right) begin
               tcol_d  = pcol_q + 6'd1;
               trow_d  = prow_q;
               state_d = (pcol_q < 6'(MAX_BCOL)) ? REQ : PLAY;
            end
         end
         REQ: state_d = CHECK;
         CHECK: begin
            if (i_rom_data == 16'h0000) begin
               pcol_d  = tcol_q;
               prow_d  = trow_q;
               state_d = (tcol_q == E_COL && trow_q == E_ROW) ? WIN : PLAY;
            end else begin
               state_d = PLAY;
            end
         end
         default: begin
            if (i_control) begin
               state_d = IDLE;
               pcol_d  = S_COL;
               prow_d  = S_ROW;
               tick_d  = '0;
               ivl_d   = 6'd0;
            end
         end
      endcase
      if (active && ivl_d == 6'(MAX_INTERVALS) && state_d != WIN) begin
         state_d = LOSE;
         pcol_d  = pcol_q;
         prow_d  = prow_q;
      end
      rom_en_d   = (state_d == REQ);
      rom_addr_d = rom_en_d ? {trow_d[4:0], tcol_d} : 11'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pcol_q     <= S_COL;
         prow_q     <= S_ROW;
         tcol_q     <= 6'd0;
         trow_q     <= 6'd0;
         tick_q     <= '0;
         ivl_q      <= 6'd0;
         rom_en_q   <= 1'b0;
         rom_addr_q <= 11'd0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcol_q     <= pcol_d;
         prow_q     <= prow_d;
         tcol_q     <= tcol_d;
         trow_q     <= trow_d;
         tick_q     <= tick_d;
         ivl_q      <= ivl_d;
         rom_en_q   <= rom_en_d;
         rom_addr_q <= rom_addr_d;
         win_q      <= (state_d == WIN);
         lose_q     <= (state_d == LOSE);
      end
   end

   assign o_rom_en                = rom_en_q;
   assign o_rom_addr              = rom_addr_q;
   assign o_player_bcol           = pcol_q;
   assign o_player_brow           = prow_q;
   assign o_exit_bcol             = E_COL;
   assign o_exit_brow             = E_ROW;
   assign o_two_seconds_intervals = ivl_q;
   assign o_win                   = win_q;
   assign o_lose                  = lose_q;
endmodule

// File: tb/tb_maze_controller.sv
// tb_maze_controller: directed vectors for moves/walls/edges plus timer, lose, win-priority and reset sequences.
module tb_maze_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        ctl, up, dn, lf, rt, rom_en, win, lose;
   logic [10:0] rom_addr;
   logic [15:0] rom_data;
   logic [5:0]  pcol, prow, ecol, erow, ivl;

   logic        t_ctl, t_rt, t_rom_en, t_win, t_lose;
   logic [10:0] t_rom_addr;
   logic [15:0] t_rom_data;
   logic [5:0]  t_pcol, t_prow, t_ecol, t_erow, t_ivl;

   logic [15:0] rom [2048];

   maze_controller #(.TICKS_PER_INTERVAL(1000), .MAX_INTERVALS(40)) dut (
      .clk(clk), .rst(rst), .i_control(ctl), .i_up(up), .i_down(dn), .i_left(lf), .i_right(rt),
      .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_player_bcol(pcol), .o_player_brow(prow), .o_exit_bcol(ecol), .o_exit_brow(erow),
      .o_two_seconds_intervals(ivl), .o_win(win), .o_lose(lose));

   maze_controller #(.START_BCOL(37), .START_BROW(27), .TICKS_PER_INTERVAL(4), .MAX_INTERVALS(3)) dut_t (
      .clk(clk), .rst(rst), .i_control(t_ctl), .i_up(1'b0), .i_down(1'b0), .i_left(1'b0), .i_right(t_rt),
      .o_rom_en(t_rom_en), .o_rom_addr(t_rom_addr), .i_rom_data(t_rom_data),
      .o_player_bcol(t_pcol), .o_player_brow(t_prow), .o_exit_bcol(t_ecol), .o_exit_brow(t_erow),
      .o_two_seconds_intervals(t_ivl), .o_win(t_win), .o_lose(t_lose));

   // ROM model: data one cycle after the enable, garbage otherwise.
   always @(posedge clk) begin
      rom_data   <= rom_en ? rom[rom_addr] : 16'hDEAD;
      t_rom_data <= t_rom_en ? rom[t_rom_addr] : 16'hDEAD;
   end

   int tests = 0, fails = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic apply(input logic [4:0] mv, output int n_en, output logic [10:0] a);
      {ctl, up, dn, lf, rt} = mv;
      @(posedge clk); #1;
      {ctl, up, dn, lf, rt} = '0;
      n_en = 0;
      a = '0;
      repeat (3) begin
         @(negedge clk);
         if (rom_en) begin
            n_en++;
            a = rom_addr;
         end
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      string       name;
      logic [4:0]  mv;
      int          n_en;
      logic [10:0] addr;
      logic [5:0]  col, row;
   } vec_t;

   vec_t v[14];

   initial begin
      int          n;
      logic [10:0] a;
      for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
      rom[11'h081] = 16'hF000;
      v[0]  = '{"idle_right",       5'b00001, 0, 11'h000, 6'd1, 6'd1};
      v[1]  = '{"start",            5'b10000, 0, 11'h000, 6'd1, 6'd1};
      v[2]  = '{"right",            5'b00001, 1, 11'h042, 6'd2, 6'd1};
      v[3]  = '{"left",             5'b00010, 1, 11'h041, 6'd1, 6'd1};
      v[4]  = '{"down_wall",        5'b00100, 1, 11'h081, 6'd1, 6'd1};
      v[5]  = '{"left_to_edge",     5'b00010, 1, 11'h040, 6'd0, 6'd1};
      v[6]  = '{"left_oob",         5'b00010, 0, 11'h000, 6'd0, 6'd1};
      v[7]  = '{"up_to_top",        5'b01000, 1, 11'h000, 6'd0, 6'd0};
      v[8]  = '{"up_oob",           5'b01000, 0, 11'h000, 6'd0, 6'd0};
      v[9]  = '{"up_over_right",    5'b01001, 0, 11'h000, 6'd0, 6'd0};
      v[10] = '{"down_over_left",   5'b00110, 1, 11'h040, 6'd0, 6'd1};
      v[11] = '{"left_over_right",  5'b00011, 0, 11'h000, 6'd0, 6'd1};
      v[12] = '{"right_back",       5'b00001, 1, 11'h041, 6'd1, 6'd1};
      v[13] = '{"ctl_ignored_wall", 5'b10100, 1, 11'h081, 6'd1, 6'd1};

      {ctl, up, dn, lf, rt} = '0;
      t_ctl = 1'b0;
      t_rt  = 1'b0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_col", pcol, 1);
      chk("rst_row", prow, 1);
      chk("rst_exit_col", ecol, 38);
      chk("rst_exit_row", erow, 27);
      chk("rst_ivl", ivl, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_win_lose", {win, lose}, 0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         apply(v[i].mv, n, a);
         chk({v[i].name, "_en"}, n, v[i].n_en);
         chk({v[i].name, "_addr"}, a, v[i].addr);
         chk({v[i].name, "_col"}, pcol, v[i].col);
         chk({v[i].name, "_row"}, prow, v[i].row);
         chk({v[i].name, "_wl"}, {win, lose}, 0);
      end

      // Reset while the ROM request is outstanding.
      rt = 1'b1;
      @(posedge clk); #1;
      rt = 1'b0;
      chk("mid_req_en", rom_en, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_en", rom_en, 0);
      chk("mid_rst_addr", rom_addr, 0);
      chk("mid_rst_col", pcol, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_col_after", pcol, 1);
      apply(5'b00001, n, a);
      chk("post_rst_idle_en", n, 0);
      chk("post_rst_idle_col", pcol, 1);

      // Timer runs to MAX_INTERVALS and loses.
      t_ctl = 1'b1;
      @(posedge clk); #1;
      t_ctl = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("ivl_at_%0d", k), t_ivl, k / 4);
         chk($sformatf("lose_at_%0d", k), t_lose, (k == 12) ? 1 : 0);
      end
      t_rt = 1'b1;
      @(posedge clk); #1;
      t_rt = 1'b0;
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (t_rom_en) n++;
         @(posedge clk); #1;
      end
      chk("lose_move_en", n, 0);
      chk("lose_move_col", t_pcol, 37);
      chk("lose_ivl_frozen", t_ivl, 3);
      chk("lose_held", t_lose, 1);
      t_ctl = 1'b1;
      @(posedge clk); #1;
      t_ctl = 1'b0;
      chk("restart_ivl", t_ivl, 0);
      chk("restart_lose", t_lose, 0);
      chk("restart_col", t_pcol, 37);

      // Move onto exit committed in the same cycle the last interval expires.
      t_ctl = 1'b1;
      @(posedge clk); #1;
      t_ctl = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      t_rt = 1'b1;
      @(posedge clk); #1;
      t_rt = 1'b0;
      n = 0;
      a = '0;
      repeat (2) begin
         @(negedge clk);
         if (t_rom_en) begin
            n++;
            a = t_rom_addr;
         end
         @(posedge clk); #1;
      end
      chk("win_en", n, 1);
      chk("win_addr", a, 11'h6E6);
      chk("win_win", t_win, 1);
      chk("win_lose", t_lose, 0);
      chk("win_col", t_pcol, 38);
      chk("win_row", t_prow, 27);
      chk("win_ivl", t_ivl, 3);
      @(posedge clk); #1;
      chk("win_held", {t_win, t_lose}, 2'b10);
      t_ctl = 1'b1;
      @(posedge clk); #1;
      t_ctl = 1'b0;
      chk("win_restart", {t_win, t_lose, t_pcol}, {2'b00, 6'd37});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
